// File: rtl/expr_eval_stack.sv
// expr_eval_stack: streaming ASCII expression evaluator (shunting-yard).
// One character per in_valid/in_ready handshake. Operands and operators live
// on two small stacks. The result is a signed DATA_W-bit value.
// Optional feature macro: EXPR_EVAL_DIV_EN enables the '/' operator.
module expr_eval_stack #(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        ascii_in,
    output logic              in_ready,
    output logic              valid,
    output logic [DATA_W-1:0] result,
    output logic              err,
    output logic [2:0]        err_code
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL = PW'(STACK_DEPTH);
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [PW-1:0] TWO  = PW'(2);

    // Operator stack encoding; OP_CL only ever lives in the pending register
    localparam logic [2:0] OP_LP = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2,
                           OP_MUL = 3'd3, OP_DIV = 3'd4, OP_CL = 3'd5;
    localparam logic [2:0] E_ILL = 3'd1, E_OVF = 3'd2, E_SYN = 3'd3;
`ifdef EXPR_EVAL_DIV_EN
    localparam logic [2:0] E_DIV = 3'd4;
`endif

    typedef enum logic [2:0] {ACCEPT, REDUCE, FLUSH, OUT, DRAIN} state_t;

    state_t            state;
    logic [DATA_W-1:0] opnd [STACK_DEPTH];
    logic [2:0]        ostk [STACK_DEPTH];
    logic [PW-1:0]     sp, osp;
    logic [2:0]        pend, err_lat;

    assign in_ready = (state == ACCEPT) || (state == DRAIN);

    function automatic logic prec_hi(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    logic                     ch_dig, ch_op;
    logic [3:0]               ch_val;
    logic [2:0]               ch_opc;
    logic signed [DATA_W-1:0] a, b, app_res;
    logic signed [2*DATA_W-1:0] prod;
    logic [2:0]               top_op, app_code;
    logic                     reduce_new, reduce_pend;

    // Character classification
    always_comb begin
        ch_dig = 1'b0;
        ch_val = ascii_in[3:0];
        ch_op  = 1'b1;
        ch_opc = OP_ADD;
        if (ascii_in >= "0" && ascii_in <= "9") ch_dig = 1'b1;
        if ((ascii_in >= "a" && ascii_in <= "f") || (ascii_in >= "A" && ascii_in <= "F")) begin
            ch_dig = 1'b1;
            ch_val = ascii_in[3:0] + 4'd9;
        end
        case (ascii_in)
            "+":     ch_opc = OP_ADD;
            "-":     ch_opc = OP_SUB;
            "*":     ch_opc = OP_MUL;
`ifdef EXPR_EVAL_DIV_EN
            "/":     ch_opc = OP_DIV;
`endif
            default: ch_op = 1'b0;
        endcase
    end

    // Top-of-stack apply step: result and error check for (a top_op b)
    always_comb begin
        a        = opnd[AW'(sp - TWO)];
        b        = opnd[AW'(sp - ONE)];
        top_op   = ostk[AW'(osp - ONE)];
        prod     = a * b;
        app_code = 3'd0;
        if (sp < TWO) app_code = E_SYN;
`ifdef EXPR_EVAL_DIV_EN
        else if (top_op == OP_DIV && b == '0) app_code = E_DIV;
`endif
        case (top_op)
            OP_ADD:  app_res = a + b;
            OP_SUB:  app_res = a - b;
            OP_MUL:  app_res = prod[DATA_W-1:0];
`ifdef EXPR_EVAL_DIV_EN
            // min / -1 overflows; negation wraps back to min as required
            OP_DIV:  app_res = (b == '1) ? -a : ((b == '0) ? '0 : a / b);
`endif
            default: app_res = '0;
        endcase
        // left-associative: reduce while top is an operator of >= precedence
        reduce_new  = (osp != '0) && (top_op != OP_LP) && (prec_hi(top_op) || !prec_hi(ch_opc));
        reduce_pend = (osp != '0) && (top_op != OP_LP) && (prec_hi(top_op) || !prec_hi(pend));
    end

    // Main FSM: stacks, pending operator, error latch and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCEPT;
            sp       <= '0;
            osp      <= '0;
            pend     <= OP_ADD;
            err_lat  <= '0;
            valid    <= 1'b0;
            result   <= '0;
            err      <= 1'b0;
            err_code <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                opnd[i] <= '0;
                ostk[i] <= OP_LP;
            end
        end else begin
            case (state)
                ACCEPT: if (in_valid) begin
                    if (ch_dig) begin
                        if (sp == FULL) begin err_lat <= E_OVF; state <= DRAIN; end
                        else begin opnd[AW'(sp)] <= {{(DATA_W-4){1'b0}}, ch_val}; sp <= sp + ONE; end
                    end else if (ascii_in == " ") begin
                    end else if (ascii_in == "(") begin
                        if (osp == FULL) begin err_lat <= E_OVF; state <= DRAIN; end
                        else begin ostk[AW'(osp)] <= OP_LP; osp <= osp + ONE; end
                    end else if (ch_op) begin
                        if (reduce_new) begin pend <= ch_opc; state <= REDUCE; end
                        else if (osp == FULL) begin err_lat <= E_OVF; state <= DRAIN; end
                        else begin ostk[AW'(osp)] <= ch_opc; osp <= osp + ONE; end
                    end else if (ascii_in == ")") begin
                        pend  <= OP_CL;
                        state <= REDUCE;
                    end else if (ascii_in == "=") begin
                        state <= FLUSH;
                    end else begin
                        err_lat <= E_ILL;
                        state   <= DRAIN;
                    end
                end
                REDUCE: begin
                    if (pend == OP_CL && osp == '0) begin
                        err_lat <= E_SYN; state <= DRAIN;
                    end else if (pend == OP_CL && top_op == OP_LP) begin
                        osp <= osp - ONE; state <= ACCEPT;
                    end else if (pend != OP_CL && !reduce_pend) begin
                        if (osp == FULL) begin err_lat <= E_OVF; state <= DRAIN; end
                        else begin ostk[AW'(osp)] <= pend; osp <= osp + ONE; state <= ACCEPT; end
                    end else if (app_code != '0) begin
                        err_lat <= app_code; state <= DRAIN;
                    end else begin
                        opnd[AW'(sp - TWO)] <= app_res;
                        sp  <= sp - ONE;
                        osp <= osp - ONE;
                    end
                end
                // '=' already consumed here, so any error goes straight to OUT.
                // A drained expression also passes through for one cycle.
                FLUSH: begin
                    if (err_lat != '0 || osp == '0 || top_op == OP_LP || app_code != '0) begin
                        valid <= 1'b1;
                        state <= OUT;
                        if (err_lat != '0)         begin err_code <= err_lat;  err <= 1'b1; result <= '0; end
                        else if (osp != '0)        begin err_code <= (top_op == OP_LP) ? E_SYN : app_code;
                                                         err <= 1'b1; result <= '0; end
                        else if (sp == ONE)        begin err_code <= '0;       err <= 1'b0; result <= b; end
                        else                       begin err_code <= E_SYN;    err <= 1'b1; result <= '0; end
                    end else begin
                        opnd[AW'(sp - TWO)] <= app_res;
                        sp  <= sp - ONE;
                        osp <= osp - ONE;
                    end
                end
                OUT: begin
                    valid   <= 1'b0;
                    sp      <= '0;
                    osp     <= '0;
                    err_lat <= '0;
                    state   <= ACCEPT;
                end
                DRAIN: if (in_valid && ascii_in == "=") state <= FLUSH;
                default: state <= ACCEPT;
            endcase
        end
    end
endmodule
